// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU function codes, condition
// selects and the condition-code register layout with its reset value.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  typedef enum logic [3:0] {
    CND_ALWAYS = 4'd0,
    CND_LE     = 4'd1,
    CND_L      = 4'd2,
    CND_E      = 4'd3,
    CND_NE     = 4'd4,
    CND_GE     = 4'd5,
    CND_G      = 4'd6
  } cnd_fn_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Zero flag set out of reset so an unconditional-looking "E" test is true
  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Two's-complement overflow from the sign bits only. For subtraction the
  // operands must have differing signs; for addition, matching signs. In
  // both cases the result sign must differ from operand a.
  function automatic logic arith_overflow(
    input logic a_msb,
    input logic b_msb,
    input logic out_msb,
    input logic is_sub
  );
    logic sign_cond;
    sign_cond = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
    return sign_cond & (out_msb != a_msb);
  endfunction

endpackage

// File: rtl/cc_cond_eval.sv
// Condition evaluator: maps a condition select and the three flags to a
// single taken/true bit. Purely combinational; shared with decode cmov.
module cc_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cnd_fn,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd
);

  logic lt;

  assign lt = sf ^ of;

  // Select the condition; unused encodings evaluate false
  always_comb begin
    cnd = 1'b0;
    case (cnd_fn_e'(cnd_fn))
      CND_ALWAYS: cnd = 1'b1;
      CND_LE:     cnd = lt | zf;
      CND_L:      cnd = lt;
      CND_E:      cnd = zf;
      CND_NE:     cnd = ~zf;
      CND_GE:     cnd = ~lt;
      CND_G:      cnd = ~lt & ~zf;
      default:    cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute-stage back end: derives flags from the ALU result, keeps the
// condition-code register, evaluates the branch/cmov condition from the
// registered flags and latches the E->M pipeline register.
module exec_cc_stage
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_valid,
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic [1:0]   alu_fn,
  input  logic         set_cc,
  input  logic         cc_inhibit,
  input  logic [3:0]   cnd_fn,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         e_cnd,
  output logic         m_valid,
  output logic [W-1:0] m_valE,
  output logic         m_cnd
);

  cc_t          cc_reg;
  cc_t          cc_next;
  logic         cc_we;
  logic         cnd_now;
  logic         m_valid_reg;
  logic [W-1:0] m_vale_reg;
  logic         m_cnd_reg;

  // Only the sign bits of the operands matter for overflow detection
  logic unused_operand_bits;
  assign unused_operand_bits = ^{alu_a[W-2:0], alu_b[W-2:0]};

  // Flags the current E instruction would produce
  always_comb begin
    cc_next.zf = (alu_out == '0);
    cc_next.sf = alu_out[W-1];
    cc_next.of = 1'b0;
    case (alu_fn_e'(alu_fn))
      ALU_ADD: cc_next.of = arith_overflow(alu_a[W-1], alu_b[W-1], alu_out[W-1], 1'b0);
      ALU_SUB: cc_next.of = arith_overflow(alu_a[W-1], alu_b[W-1], alu_out[W-1], 1'b1);
      default: cc_next.of = 1'b0;
    endcase
  end

  // A stalled or inhibited instruction must not disturb the flags
  assign cc_we = e_valid & set_cc & ~cc_inhibit & ~m_stall;

  // Condition-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_reg <= CC_RESET;
    end else if (cc_we) begin
      cc_reg <= cc_next;
    end
  end

  // Condition uses the flags as they were before this instruction
  cc_cond_eval u_cond (
    .cnd_fn (cnd_fn),
    .zf     (cc_reg.zf),
    .sf     (cc_reg.sf),
    .of     (cc_reg.of),
    .cnd    (cnd_now)
  );

  // E->M register: stall holds (and beats bubble), bubble clears, else load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg <= 1'b0;
      m_vale_reg  <= '0;
      m_cnd_reg   <= 1'b0;
    end else if (m_stall) begin
      m_valid_reg <= m_valid_reg;
      m_vale_reg  <= m_vale_reg;
      m_cnd_reg   <= m_cnd_reg;
    end else if (m_bubble) begin
      m_valid_reg <= 1'b0;
      m_vale_reg  <= '0;
      m_cnd_reg   <= 1'b0;
    end else begin
      m_valid_reg <= e_valid;
      m_vale_reg  <= alu_out;
      m_cnd_reg   <= cnd_now;
    end
  end

  assign cc_zf   = cc_reg.zf;
  assign cc_sf   = cc_reg.sf;
  assign cc_of   = cc_reg.of;
  assign e_cnd   = cnd_now;
  assign m_valid = m_valid_reg;
  assign m_valE  = m_vale_reg;
  assign m_cnd   = m_cnd_reg;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Self-checking bench for exec_cc_stage: directed scenarios plus random
// traffic compared against an arithmetic reference model.
module tb_exec_cc_stage;

  logic        clk;
  logic        rst_n;
  logic        e_valid;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_out;
  logic [1:0]  alu_fn;
  logic        set_cc;
  logic        cc_inhibit;
  logic [3:0]  cnd_fn;
  logic        m_stall;
  logic        m_bubble;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;
  logic        e_cnd;
  logic        m_valid;
  logic [63:0] m_valE;
  logic        m_cnd;

  int checks;
  int errors;

  // reference model state
  bit          r_zf, r_sf, r_of;
  bit          r_valid, r_cnd;
  logic [63:0] r_vale;

  exec_cc_stage #(.W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .e_valid    (e_valid),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_fn     (alu_fn),
    .set_cc     (set_cc),
    .cc_inhibit (cc_inhibit),
    .cnd_fn     (cnd_fn),
    .m_stall    (m_stall),
    .m_bubble   (m_bubble),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of),
    .e_cnd      (e_cnd),
    .m_valid    (m_valid),
    .m_valE     (m_valE),
    .m_cnd      (m_cnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition from the signed-compare meaning of each select
  function automatic bit ref_cnd(input logic [3:0] fn, input bit z, input bit s, input bit o);
    bit less;
    less = (s != o);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return less || z;
      4'd2: return less;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !less;
      4'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Overflow: the exact signed result does not fit in 64 bits
  function automatic bit ref_of(input logic [1:0] fn, input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] wide;
    logic signed [64:0] sa;
    logic signed [64:0] sb;
    sa = $signed({a[63], a});
    sb = $signed({b[63], b});
    if (fn == 2'd0)      wide = sa + sb;
    else if (fn == 2'd1) wide = sa - sb;
    else                 return 1'b0;
    return wide[64] != wide[63];
  endfunction

  function automatic logic [63:0] ref_alu(input logic [1:0] fn, input logic [63:0] a, input logic [63:0] b);
    case (fn)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic apply(input bit v, input logic [63:0] a, input logic [63:0] b, input logic [1:0] fn,
                       input bit sc, input bit inh, input logic [3:0] cf, input bit st, input bit bb);
    e_valid    = v;
    alu_a      = a;
    alu_b      = b;
    alu_fn     = fn;
    alu_out    = ref_alu(fn, a, b);
    set_cc     = sc;
    cc_inhibit = inh;
    cnd_fn     = cf;
    m_stall    = st;
    m_bubble   = bb;
  endtask

  // One clock edge, advancing the model with the inputs present at the edge
  task automatic tick();
    bit c;
    @(posedge clk);
    c = ref_cnd(cnd_fn, r_zf, r_sf, r_of);
    if (!m_stall) begin
      if (m_bubble) begin
        r_valid = 0; r_vale = '0; r_cnd = 0;
      end else begin
        r_valid = e_valid; r_vale = alu_out; r_cnd = c;
      end
    end
    if (e_valid && set_cc && !cc_inhibit && !m_stall) begin
      r_zf = (alu_out == 64'd0);
      r_sf = alu_out[63];
      r_of = ref_of(alu_fn, alu_a, alu_b);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    r_zf = 1; r_sf = 0; r_of = 0;
    r_valid = 0; r_vale = '0; r_cnd = 0;
  endtask

  task automatic test_reset();
    apply(1, 64'h1234, 64'h0, 2'd0, 1, 0, 4'd0, 0, 0);
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cc_zf, cc_sf, cc_of, m_valid, m_cnd} !== 5'b10000 || m_valE !== 64'd0) begin
      errors++;
      $display("FAIL reset: flags/valid/cnd=%b valE=%h required 10000 / 0", {cc_zf, cc_sf, cc_of, m_valid, m_cnd}, m_valE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 64'h0, 64'h0, 2'd0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_sub_overflow();
    apply(1, 64'h8000_0000_0000_0000, 64'h1, 2'd1, 1, 0, 4'd2, 0, 0);
    tick();
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b001) begin
      errors++;
      $display("FAIL sub_overflow_flags: zf/sf/of=%b required 001", {cc_zf, cc_sf, cc_of});
    end
    apply(1, 64'h0, 64'h0, 2'd2, 0, 0, 4'd2, 0, 0);
    #1;
    checks++;
    if (e_cnd !== 1'b1) begin
      errors++;
      $display("FAIL sub_overflow_L: e_cnd=%b required 1", e_cnd);
    end
    tick();
  endtask

  task automatic test_add_zero();
    apply(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 1, 0, 4'd0, 0, 0);
    tick();
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL add_zero_flags: zf/sf/of=%b required 100", {cc_zf, cc_sf, cc_of});
    end
    apply(1, 64'h0, 64'h0, 2'd3, 0, 0, 4'd3, 0, 0);
    #1;
    checks++;
    if (e_cnd !== 1'b1) begin
      errors++;
      $display("FAIL add_zero_E: e_cnd=%b required 1", e_cnd);
    end
    cnd_fn = 4'd6;
    #1;
    checks++;
    if (e_cnd !== 1'b0) begin
      errors++;
      $display("FAIL add_zero_G: e_cnd=%b required 0", e_cnd);
    end
    tick();
  endtask

  task automatic test_inhibit_stall();
    logic [63:0] held;
    // flags currently 100; a result of 0x8000... would give 010
    apply(1, 64'h8000_0000_0000_0000, 64'h0, 2'd3, 1, 1, 4'd0, 0, 0);
    tick();
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL inhibit_cc: zf/sf/of=%b required 100", {cc_zf, cc_sf, cc_of});
    end
    held = m_valE;
    apply(1, 64'h8000_0000_0000_0000, 64'h0, 2'd3, 1, 0, 4'd0, 1, 0);
    tick();
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL stall_cc: zf/sf/of=%b required 100", {cc_zf, cc_sf, cc_of});
    end
    checks++;
    if (m_valE !== held || m_valE !== r_vale) begin
      errors++;
      $display("FAIL stall_m_hold: m_valE=%h required %h", m_valE, held);
    end
  endtask

  task automatic test_bubble_vs_stall();
    apply(1, 64'h1234, 64'h0, 2'd0, 0, 0, 4'd0, 0, 0);
    tick();
    apply(1, 64'h5678, 64'h0, 2'd0, 0, 0, 4'd0, 1, 1);
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_valE !== 64'h1234) begin
      errors++;
      $display("FAIL stall_beats_bubble: valid=%b valE=%h required 1 / 1234", m_valid, m_valE);
    end
    apply(1, 64'h5678, 64'h0, 2'd0, 0, 0, 4'd0, 0, 1);
    tick();
    checks++;
    if (m_valid !== 1'b0 || m_valE !== 64'h0 || m_cnd !== 1'b0) begin
      errors++;
      $display("FAIL bubble: valid=%b valE=%h cnd=%b required 0 / 0 / 0", m_valid, m_valE, m_cnd);
    end
  endtask

  task automatic test_latency();
    apply(1, 64'h55, 64'h0, 2'd0, 0, 0, 4'd0, 0, 0);
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_valE !== 64'h55 || m_cnd !== 1'b1) begin
      errors++;
      $display("FAIL latency_load: valid=%b valE=%h cnd=%b required 1 / 55 / 1", m_valid, m_valE, m_cnd);
    end
    apply(0, 64'h0, 64'h0, 2'd0, 0, 0, 4'd0, 0, 0);
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_invalid: valid=%b required 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    // cycle N: 5-7 sets SF; cycle N+1: L must see it, not the old flags
    apply(1, 64'd5, 64'd7, 2'd1, 1, 0, 4'd2, 0, 0);
    #1;
    checks++;
    if (e_cnd !== ref_cnd(4'd2, r_zf, r_sf, r_of)) begin
      errors++;
      $display("FAIL b2b_pre: e_cnd=%b required %b", e_cnd, ref_cnd(4'd2, r_zf, r_sf, r_of));
    end
    tick();
    apply(1, 64'h0, 64'h0, 2'd2, 0, 0, 4'd2, 0, 0);
    #1;
    checks++;
    if (e_cnd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_post: e_cnd=%b required 1", e_cnd);
    end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: a = 64'h8000_0000_0000_0000;
        1: a = 64'h7FFF_FFFF_FFFF_FFFF;
        2: b = a;
        3: b = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      apply($urandom_range(0, 3) != 0, a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (e_cnd !== ref_cnd(cnd_fn, r_zf, r_sf, r_of)) begin
        errors++;
        $display("FAIL rand_e_cnd[%0d]: e_cnd=%b required %b fn=%0d", i, e_cnd, ref_cnd(cnd_fn, r_zf, r_sf, r_of), cnd_fn);
      end
      tick();
      checks++;
      if ({cc_zf, cc_sf, cc_of, m_valid, m_cnd} !== {r_zf, r_sf, r_of, r_valid, r_cnd} || m_valE !== r_vale) begin
        errors++;
        $display("FAIL rand_state[%0d]: zf/sf/of/valid/cnd=%b valE=%h required %b / %h", i,
                 {cc_zf, cc_sf, cc_of, m_valid, m_cnd}, m_valE, {r_zf, r_sf, r_of, r_valid, r_cnd}, r_vale);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    apply(1, 64'h8000_0000_0000_0000, 64'h0, 2'd0, 1, 0, 4'd0, 0, 0);
    tick();
    apply(1, 64'h0, 64'h0, 2'd0, 1, 0, 4'd0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cc_zf, cc_sf, cc_of, m_valid, m_cnd} !== 5'b10000 || m_valE !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: flags/valid/cnd=%b valE=%h required 10000 / 0", {cc_zf, cc_sf, cc_of, m_valid, m_cnd}, m_valE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 64'h0, 64'h0, 2'd0, 0, 0, 4'd0, 0, 0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    apply(0, 64'h0, 64'h0, 2'd0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    test_reset();
    test_sub_overflow();
    test_add_zero();
    test_inhibit_stall();
    test_bubble_vs_stall();
    test_latency();
    test_back_to_back();
    test_random();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_cc_stage.md
Name: exec_cc_stage

Overview:
- Execute-stage back end, directly downstream of the 64-bit ALU (adder/subtractor/logic).
- Consumes the ALU result, its operands and the function code.
- Derives ZF/SF/OF and holds them in the condition-code register.
- Evaluates the branch/cmov condition and latches the E->M pipeline register, with stall/bubble control from the hazard unit.

Parameters:
- W, 64, datapath width; flag bit positions derive from W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- e_valid  in  1  instruction present in E this cycle
- alu_a  in  W  ALU operand a
- alu_b  in  W  ALU operand b
- alu_out  in  W  ALU result: a+b, a-b, a&b or a^b
- alu_fn  in  2  0=ADD, 1=SUB, 2=AND, 3=XOR
- set_cc  in  1  instruction writes condition codes
- cc_inhibit  in  1  exception downstream; block CC update
- cnd_fn  in  4  condition select
- m_stall  in  1  hold M register and CC
- m_bubble  in  1  insert bubble into M
- cc_zf  out  1  registered zero flag
- cc_sf  out  1  registered sign flag
- cc_of  out  1  registered overflow flag
- e_cnd  out  1  combinational condition for the E instruction, from registered CC
- m_valid  out  1  M-stage valid
- m_valE  out  W  M-stage latched ALU result
- m_cnd  out  1  M-stage latched condition

Behaviour:
- Reset (rst_n low, asynchronous): cc_zf=1, cc_sf=0, cc_of=0, m_valid=0, m_valE=0, m_cnd=0. All state is released on the first clk edge after rst_n rises.
- Next-flag computation (combinational):
  - zf_n = (alu_out == 0).
  - sf_n = alu_out[W-1].
  - ADD: of_n = (a[W-1]==b[W-1]) & (out[W-1]!=a[W-1]).
  - SUB: of_n = (a[W-1]!=b[W-1]) & (out[W-1]!=a[W-1]).
  - AND/XOR: of_n = 0.
- CC update: at a clk edge, CC <= next flags only when e_valid & set_cc & ~cc_inhibit & ~m_stall. Otherwise CC holds.
- e_cnd is evaluated from the registered CC, i.e. the flags before the current instruction's update. cnd_fn:
  - 0: always 1
  - 1 (LE): (SF^OF)|ZF
  - 2 (L): SF^OF
  - 3 (E): ZF
  - 4 (NE): ~ZF
  - 5 (GE): ~(SF^OF)
  - 6 (G): ~(SF^OF)&~ZF
  - 7..15: 0
- M register, one-cycle latency from E:
  - m_stall=1: hold all M fields. Stall wins over a simultaneous bubble.
  - else m_bubble=1: m_valid=0, m_valE=0, m_cnd=0.
  - else: m_valid<=e_valid, m_valE<=alu_out, m_cnd<=e_cnd.
  - e_valid=0 with no stall/bubble loads m_valid=0; m_valE and m_cnd are loaded regardless (don't-care).
- Back-to-back behaviour: a set_cc instruction in cycle N followed by a jump in E at N+1 sees the updated CC at N+1. No bypass exists inside a single cycle.
- Reset asserted mid-stall: reset dominates immediately.
- Width rule: no sign extension or truncation; all arithmetic checks are on W-bit values.

Decomposition:
- Shared package (alu_pkg):
  - ALU_ADD/ALU_SUB/ALU_AND/ALU_XOR encodings.
  - CND_ALWAYS..CND_G encodings.
  - CC reset constant (ZF=1, SF=0, OF=0).
- One sub-module: cc_cond_eval. Combinational; takes cnd_fn, zf, sf, of and produces cnd. It is reused by the decode-stage cmov logic.

Test Plan:
- Reset: rst_n low mid-cycle -> immediately cc_zf=1, cc_sf=0, cc_of=0, m_valid=0, m_valE=0.
- SUB overflow: a=0x8000000000000000, b=1, out=0x7FFFFFFFFFFFFFFF, fn=SUB, set_cc=1 -> next cycle ZF=0, SF=0, OF=1; cnd_fn=2 (L) gives e_cnd=1.
- ADD zero: a=0xFFFFFFFFFFFFFFFF, b=1, out=0, fn=ADD, set_cc=1 -> ZF=1, SF=0, OF=0; cnd_fn=3 gives e_cnd=1, cnd_fn=6 gives 0.
- Inhibit/stall: set_cc=1 with cc_inhibit=1, then with m_stall=1 -> CC unchanged both cycles; M fields held during the stall.
- Bubble vs stall: m_bubble=1 alone -> m_valid=0, m_valE=0. m_bubble=1 with m_stall=1 -> M holds its prior value (e.g. valE=0x1234, valid=1).
- Pipeline latency: e_valid=1, out=0x55 with no stall -> m_valid=1, m_valE=0x55 one edge later. Then e_valid=0 -> m_valid=0 the following edge.
